// File: rtl/temporal_clause_ring_buffer.sv
// Ring buffer of DEPTH flip records feeding break-value evaluation; ring-order allocation, indexed registered reads.
// Optional same-cycle write-to-read forwarding is enabled by defining TEMPORAL_BUFFER_WRITE_BYPASS_EN.
module temporal_clause_ring_buffer #(
    parameter int NSAT                     = 3,
    parameter int LITERAL_ADDRESS_WIDTH    = 11,
    parameter int MAX_CLAUSES_PER_VARIABLE = 20,
    parameter int DEPTH                    = 4,
    parameter int SLOT_BITS                = 2
) (
    input  logic                                                           clk,
    input  logic                                                           reset,
    input  logic                                                           write_valid_i,
    output logic                                                           write_ready_o,
    input  logic [MAX_CLAUSES_PER_VARIABLE*(LITERAL_ADDRESS_WIDTH+1)-1:0]  flipped_literal_multi_i,
    input  logic [(NSAT-1)*MAX_CLAUSES_PER_VARIABLE*(LITERAL_ADDRESS_WIDTH+1)-1:0] clause_table_literals_multi_i,
    output logic [SLOT_BITS-1:0]                                           write_slot_o,
    input  logic                                                           read_valid_i,
    input  logic [SLOT_BITS-1:0]                                           read_index_i,
    input  logic                                                           read_release_i,
    output logic [NSAT*MAX_CLAUSES_PER_VARIABLE*(LITERAL_ADDRESS_WIDTH+1)-1:0] clause_multi_o,
    output logic                                                           clause_valid_o,
    output logic                                                           read_error_o,
    output logic [SLOT_BITS:0]                                             occupancy_o,
    output logic                                                           full_o,
    output logic                                                           empty_o
);
    localparam int W   = LITERAL_ADDRESS_WIDTH + 1;
    localparam int CW  = NSAT * W;
    localparam int REC = MAX_CLAUSES_PER_VARIABLE * CW;

    logic [REC-1:0]       mem_q [DEPTH];
    logic [REC-1:0]       wr_rec_s, stored_rec_s;
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [SLOT_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [SLOT_BITS:0]   occ_q, occ_d;
    logic                 write_ready_q, write_ready_d;
    logic                 full_q, full_d, empty_q, empty_d;
    logic [REC-1:0]       clause_q, clause_d;
    logic                 clause_valid_q, clause_valid_d;
    logic                 read_error_q, read_error_d;
    logic                 slot_valid_s, accept_s, rd_hit_s, byp_s, release_s;

    // Interleave dense write-side buses into the per-clause record layout.
    always_comb begin
        wr_rec_s = '0;
        for (int i = 0; i < MAX_CLAUSES_PER_VARIABLE; i++) begin
            wr_rec_s[i*CW +: W]           = flipped_literal_multi_i[i*W +: W];
            wr_rec_s[(i*NSAT+1)*W +: CW-W] = clause_table_literals_multi_i[i*(CW-W) +: CW-W];
        end
    end

    // Read-side slot lookup; indices beyond DEPTH match nothing and so read as empty.
    always_comb begin
        slot_valid_s = 1'b0;
        stored_rec_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid_s = (read_index_i == SLOT_BITS'(i)) ? valid_q[i] : slot_valid_s;
            stored_rec_s = (read_index_i == SLOT_BITS'(i)) ? mem_q[i]   : stored_rec_s;
        end
    end

    // Handshake, read decode and next-state computation.
    always_comb begin
        accept_s  = write_valid_i & write_ready_q;
        rd_hit_s  = read_valid_i & slot_valid_s;
`ifdef TEMPORAL_BUFFER_WRITE_BYPASS_EN
        byp_s     = read_valid_i & accept_s & (read_index_i == wr_ptr_q);
`else
        byp_s     = 1'b0;
`endif
        // A bypassed slot is not yet valid, so rd_hit_s is low and its release is dropped.
        release_s = rd_hit_s & read_release_i;

        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept_s && (wr_ptr_q == SLOT_BITS'(i))) begin
                valid_d[i] = 1'b1;
            end else if (release_s && (read_index_i == SLOT_BITS'(i))) begin
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = valid_q[i];
            end
        end

        if (accept_s) begin
            wr_ptr_d = (wr_ptr_q == SLOT_BITS'(DEPTH-1)) ? {SLOT_BITS{1'b0}} : wr_ptr_q + {{(SLOT_BITS-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({accept_s, release_s})
            2'b10:   occ_d = occ_q + {{SLOT_BITS{1'b0}}, 1'b1};
            2'b01:   occ_d = occ_q - {{SLOT_BITS{1'b0}}, 1'b1};
            default: occ_d = occ_q;
        endcase
        full_d  = (occ_d == (SLOT_BITS+1)'(DEPTH));
        empty_d = (occ_d == {(SLOT_BITS+1){1'b0}});

        write_ready_d = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            write_ready_d = (wr_ptr_d == SLOT_BITS'(i)) ? ~valid_d[i] : write_ready_d;
        end

        if (byp_s) begin
            clause_d = wr_rec_s;
        end else if (rd_hit_s) begin
            clause_d = stored_rec_s;
        end else begin
            clause_d = clause_q;
        end
        clause_valid_d = rd_hit_s | byp_s;
        read_error_d   = read_valid_i & ~(rd_hit_s | byp_s);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q        <= '0;
            wr_ptr_q       <= '0;
            occ_q          <= '0;
            write_ready_q  <= 1'b1;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            clause_q       <= '0;
            clause_valid_q <= 1'b0;
            read_error_q   <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            wr_ptr_q       <= wr_ptr_d;
            occ_q          <= occ_d;
            write_ready_q  <= write_ready_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            clause_q       <= clause_d;
            clause_valid_q <= clause_valid_d;
            read_error_q   <= read_error_d;
        end
    end

    // Record storage; contents need no reset because valid flags gate every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (accept_s && (wr_ptr_q == SLOT_BITS'(i))) begin
                mem_q[i] <= wr_rec_s;
            end
        end
    end

    assign write_ready_o  = write_ready_q;
    assign write_slot_o   = wr_ptr_q;
    assign clause_multi_o = clause_q;
    assign clause_valid_o = clause_valid_q;
    assign read_error_o   = read_error_q;
    assign occupancy_o    = occ_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;

endmodule

// File: tb/tb_temporal_clause_ring_buffer.sv
// Directed scoreboard bench for temporal_clause_ring_buffer (DEPTH=4 main instance, DEPTH=3 range-check instance).
module tb_temporal_clause_ring_buffer;
    localparam int NSAT = 3;
    localparam int MC   = 20;
    localparam int W    = 12;
    localparam int REC  = NSAT * MC * W;
    localparam int FW   = MC * W;
    localparam int CTW  = (NSAT - 1) * MC * W;

    typedef struct {
        logic           ok;
        logic [REC-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic           write_valid_i = 1'b0, read_valid_i = 1'b0, read_release_i = 1'b0;
    logic [1:0]     read_index_i = 2'd0;
    logic [FW-1:0]  flip_i = '0;
    logic [CTW-1:0] ct_i = '0;
    logic           write_ready_o, clause_valid_o, read_error_o, full_o, empty_o;
    logic [1:0]     write_slot_o;
    logic [REC-1:0] clause_multi_o;
    logic [2:0]     occupancy_o;

    logic           wv3 = 1'b0, rv3 = 1'b0;
    logic [1:0]     ri3 = 2'd0;
    logic           ready3, cvalid3, err3, full3, empty3;
    logic [1:0]     slot3;
    logic [REC-1:0] clause3;
    logic [2:0]     occ3;

    temporal_clause_ring_buffer #(.NSAT(3), .LITERAL_ADDRESS_WIDTH(11), .MAX_CLAUSES_PER_VARIABLE(20),
                                  .DEPTH(4), .SLOT_BITS(2)) dut (
        .clk(clk), .reset(reset), .write_valid_i(write_valid_i), .write_ready_o(write_ready_o),
        .flipped_literal_multi_i(flip_i), .clause_table_literals_multi_i(ct_i), .write_slot_o(write_slot_o),
        .read_valid_i(read_valid_i), .read_index_i(read_index_i), .read_release_i(read_release_i),
        .clause_multi_o(clause_multi_o), .clause_valid_o(clause_valid_o), .read_error_o(read_error_o),
        .occupancy_o(occupancy_o), .full_o(full_o), .empty_o(empty_o));

    temporal_clause_ring_buffer #(.NSAT(3), .LITERAL_ADDRESS_WIDTH(11), .MAX_CLAUSES_PER_VARIABLE(20),
                                  .DEPTH(3), .SLOT_BITS(2)) dut3 (
        .clk(clk), .reset(reset), .write_valid_i(wv3), .write_ready_o(ready3),
        .flipped_literal_multi_i(flip_i), .clause_table_literals_multi_i(ct_i), .write_slot_o(slot3),
        .read_valid_i(rv3), .read_index_i(ri3), .read_release_i(1'b0),
        .clause_multi_o(clause3), .clause_valid_o(cvalid3), .read_error_o(err3),
        .occupancy_o(occ3), .full_o(full3), .empty_o(empty3));

    int             tests = 0;
    int             failed = 0;
    exp_t           sb_q[$];
    logic [REC-1:0] model_mem [4];
    logic [REC-1:0] last_clause = '0;
    logic [REC-1:0] cur_rec;

    task automatic check(input string tag, input logic [REC-1:0] obs, input logic [REC-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random record on the write buses; cur_rec gets the bench's own packed image.
    task automatic gen_rec();
        for (int i = 0; i < MC; i++) begin
            flip_i[i*W +: W]                 = W'($urandom);
            ct_i[i*(NSAT-1)*W +: (NSAT-1)*W] = 24'($urandom);
            cur_rec[i*NSAT*W +: W]           = flip_i[i*W +: W];
            cur_rec[(i*NSAT+1)*W +: (NSAT-1)*W] = ct_i[i*(NSAT-1)*W +: (NSAT-1)*W];
        end
    endtask

    task automatic push_rd(input logic ok, input logic [REC-1:0] d);
        exp_t e;
        e.ok = ok;
        e.data = ok ? d : last_clause;
        last_clause = e.data;
        sb_q.push_back(e);
    endtask

    task automatic pop_rd(input string tag);
        exp_t e;
        tests++;
        assert (sb_q.size() > 0) else begin
            failed++;
            $error("FAIL %s observed=empty scoreboard expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_valid"}, REC'(clause_valid_o), REC'(e.ok));
            check({tag, "_error"}, REC'(read_error_o), REC'(!e.ok));
            check({tag, "_data"}, clause_multi_o, e.data);
        end
    endtask

    task automatic check_status(input string tag, input logic [2:0] occ, input logic rdy, input logic [1:0] slot);
        check({tag, "_occ"}, REC'(occupancy_o), REC'(occ));
        check({tag, "_ready"}, REC'(write_ready_o), REC'(rdy));
        check({tag, "_slot"}, REC'(write_slot_o), REC'(slot));
        check({tag, "_full"}, REC'(full_o), REC'(occ == 3'd4));
        check({tag, "_empty"}, REC'(empty_o), REC'(occ == 3'd0));
    endtask

    task automatic check_reset(input string tag);
        check_status(tag, 3'd0, 1'b1, 2'd0);
        check({tag, "_cvalid"}, REC'(clause_valid_o), REC'(1'b0));
        check({tag, "_err"}, REC'(read_error_o), REC'(1'b0));
        check({tag, "_clause"}, clause_multi_o, {REC{1'b0}});
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        check_reset("reset");
        @(negedge clk) reset = 1'b0;
        tick();

        // Empty slot read right after reset.
        read_valid_i = 1'b1; read_index_i = 2'd1;
        push_rd(1'b0, '0);
        tick();
        read_valid_i = 1'b0;
        pop_rd("rd_empty");
        tick();
        check("err_pulse_end", REC'(read_error_o), REC'(1'b0));

        // Fill all four slots in ring order.
        for (int k = 0; k < 4; k++) begin
            check("fill_slot", REC'(write_slot_o), REC'(k));
            check("fill_ready", REC'(write_ready_o), REC'(1'b1));
            gen_rec();
            model_mem[k] = cur_rec;
            write_valid_i = 1'b1;
            tick();
            write_valid_i = 1'b0;
            check("fill_occ", REC'(occupancy_o), REC'(k + 1));
        end
        check_status("full", 3'd4, 1'b0, 2'd0);

        // Write while full is dropped; slot 0 keeps record 0.
        gen_rec();
        write_valid_i = 1'b1;
        tick();
        write_valid_i = 1'b0;
        check_status("ignored_wr", 3'd4, 1'b0, 2'd0);

        read_valid_i = 1'b1; read_index_i = 2'd2; read_release_i = 1'b0;
        push_rd(1'b1, model_mem[2]);
        tick();
        read_valid_i = 1'b0;
        pop_rd("rd_slot2");
        check("rd_slot2_occ", REC'(occupancy_o), REC'(3'd4));

        read_valid_i = 1'b1; read_index_i = 2'd0; read_release_i = 1'b1;
        push_rd(1'b1, model_mem[0]);
        tick();
        read_valid_i = 1'b0; read_release_i = 1'b0;
        pop_rd("rd_rel0");
        check_status("rel0", 3'd3, 1'b1, 2'd0);

        gen_rec();
        model_mem[0] = cur_rec;
        write_valid_i = 1'b1;
        tick();
        write_valid_i = 1'b0;
        check_status("rewrite0", 3'd4, 1'b0, 2'd1);
        read_valid_i = 1'b1; read_index_i = 2'd0;
        push_rd(1'b1, model_mem[0]);
        tick();
        read_valid_i = 1'b0;
        pop_rd("rd_new0");

        // Free slot 1, then write slot 1 while releasing slot 3.
        read_valid_i = 1'b1; read_index_i = 2'd1; read_release_i = 1'b1;
        push_rd(1'b1, model_mem[1]);
        tick();
        pop_rd("rd_rel1");
        check_status("rel1", 3'd3, 1'b1, 2'd1);
        gen_rec();
        model_mem[1] = cur_rec;
        write_valid_i = 1'b1; read_index_i = 2'd3;
        push_rd(1'b1, model_mem[3]);
        tick();
        write_valid_i = 1'b0; read_valid_i = 1'b0; read_release_i = 1'b0;
        pop_rd("rd_rel3_wr1");
        check_status("wr1_rel3", 3'd3, 1'b0, 2'd2);

        // Free slot 2, then write it while reading it with release.
        read_valid_i = 1'b1; read_index_i = 2'd2; read_release_i = 1'b1;
        push_rd(1'b1, model_mem[2]);
        tick();
        pop_rd("rd_rel2");
        check_status("rel2", 3'd2, 1'b1, 2'd2);
        gen_rec();
        model_mem[2] = cur_rec;
        write_valid_i = 1'b1;
`ifdef TEMPORAL_BUFFER_WRITE_BYPASS_EN
        push_rd(1'b1, cur_rec);
`else
        push_rd(1'b0, '0);
`endif
        tick();
        write_valid_i = 1'b0; read_release_i = 1'b0;
        pop_rd("rd_same_wr");
        check_status("same_wr", 3'd3, 1'b1, 2'd3);
        read_index_i = 2'd2;
        push_rd(1'b1, model_mem[2]);
        tick();
        read_valid_i = 1'b0;
        pop_rd("rd_after_same");

        // DEPTH=3 instance: index 3 is out of range and must not disturb held data.
        gen_rec();
        wv3 = 1'b1;
        tick();
        wv3 = 1'b0; rv3 = 1'b1; ri3 = 2'd0;
        tick();
        check("d3_rd0_valid", REC'(cvalid3), REC'(1'b1));
        check("d3_rd0_data", clause3, cur_rec);
        ri3 = 2'd3;
        tick();
        rv3 = 1'b0;
        check("d3_oor_err", REC'(err3), REC'(1'b1));
        check("d3_oor_valid", REC'(cvalid3), REC'(1'b0));
        check("d3_oor_data", clause3, cur_rec);
        tick();
        check("d3_err_end", REC'(err3), REC'(1'b0));

        // Fill to full, then reset asynchronously with a read pending.
        gen_rec();
        write_valid_i = 1'b1;
        tick();
        write_valid_i = 1'b0;
        check_status("refill", 3'd4, 1'b0, 2'd0);
        read_valid_i = 1'b1; read_index_i = 2'd1;
        push_rd(1'b1, model_mem[1]);
        tick();
        pop_rd("rd_before_rst");
        read_index_i = 2'd0;
        #2 reset = 1'b1;
        #1;
        sb_q.delete();
        last_clause = '0;
        check_reset("async_rst");
        check("async_rst_d3_occ", REC'(occ3), REC'(3'd0));
        read_valid_i = 1'b0;
        @(negedge clk) reset = 1'b0;
        tick();
        check_reset("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
